// File: rtl/mac_pkg.sv
// Shared types and sizing for the four-lane MAC engine.
// Operand widths, loop lengths and the control state encoding.
package mac_pkg;
   localparam int DATA_W    = 8;
   localparam int K_LEN     = 8;
   localparam int N_COL     = 4;
   localparam int ACC_W     = 19;
   localparam int NUM_LANES = 4;
   localparam int COL_W     = 2;
   localparam int K_W       = 3;
   localparam int ADDR_W    = COL_W + K_W;

   typedef enum logic [1:0] {IDLE, FETCH, MAC, HOLD} state_t;

   // ROM layout is column-major: col*K_LEN + k
   function automatic logic [ADDR_W-1:0] coef_ad(input logic [COL_W-1:0] col,
                                                 input logic [K_W-1:0]   k);
      return {col, k};
   endfunction
endpackage

// File: rtl/mac_array_if.sv
// X buffer, coefficient ROM and result handshake bundle of the MAC engine.
// master = environment side, slave = mac_array.
interface mac_array_if;
   import mac_pkg::*;

   logic              start;
   logic [DATA_W-1:0] x_in1, x_in2, x_in3, x_in4;
   logic [DATA_W-1:0] coef_data;
   logic [ADDR_W-1:0] coef_addr;
   logic              x_shift;
   logic              res_valid;
   logic              res_ready;
   logic [COL_W-1:0]  res_col;
   logic [ACC_W-1:0]  res_data1, res_data2, res_data3, res_data4;
   logic              busy;
   logic              done;

   modport master (
      output start, x_in1, x_in2, x_in3, x_in4, coef_data, res_ready,
      input  coef_addr, x_shift, res_valid, res_col,
             res_data1, res_data2, res_data3, res_data4, busy, done
   );

   modport slave (
      input  start, x_in1, x_in2, x_in3, x_in4, coef_data, res_ready,
      output coef_addr, x_shift, res_valid, res_col,
             res_data1, res_data2, res_data3, res_data4, busy, done
   );
endinterface

// File: rtl/mac_lane.sv
// One unsigned 8x8 multiplier feeding a clearable accumulator.
module mac_lane
   import mac_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_coef,
   output logic [ACC_W-1:0]  o_acc
);
   logic [2*DATA_W-1:0] w_prod;
   logic [ACC_W-1:0]    r_acc;

   assign w_prod = i_x * i_coef;
   assign o_acc  = r_acc;

   // 8 products of at most 255*255 fit in ACC_W, so no saturation
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_acc <= '0;
      else if (i_clr) r_acc <= '0;
      else if (i_en)  r_acc <= r_acc + ACC_W'(w_prod);
   end
endmodule

// File: rtl/mac_array.sv
// Four-lane MAC engine: P = X(4x8) * A(8x4), one result column per pass.
// Holds the control FSM, col/k counters and ROM address generation.
module mac_array
   import mac_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   mac_array_if.slave   bus
);
   state_t                              r_state;
   logic [COL_W-1:0]                    r_col;
   logic [K_W-1:0]                      r_k;
   logic [ADDR_W-1:0]                   r_addr;
   logic                                r_shift;
   logic                                r_valid;
   logic                                r_busy;
   logic                                r_done;
   logic [NUM_LANES-1:0][DATA_W-1:0]    w_x;
   logic [NUM_LANES-1:0][ACC_W-1:0]     w_acc;
   logic                                w_clr;
   logic                                w_en;

   assign w_x   = {bus.x_in4, bus.x_in3, bus.x_in2, bus.x_in1};
   assign w_clr = (r_state == FETCH);
   assign w_en  = (r_state == MAC);

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      mac_lane u_lane (
         .clk    (clk),
         .rst    (rst),
         .i_clr  (w_clr),
         .i_en   (w_en),
         .i_x    (w_x[g]),
         .i_coef (bus.coef_data),
         .o_acc  (w_acc[g])
      );
   end

   assign bus.coef_addr = r_addr;
   assign bus.x_shift   = r_shift;
   assign bus.res_valid = r_valid;
   assign bus.res_col   = r_col;
   assign bus.res_data1 = w_acc[0];
   assign bus.res_data2 = w_acc[1];
   assign bus.res_data3 = w_acc[2];
   assign bus.res_data4 = w_acc[3];
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;

   // ROM has one cycle of latency, so the address always runs one k ahead
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_col   <= '0;
         r_k     <= '0;
         r_addr  <= '0;
         r_shift <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_k <= '0;
               if (bus.start) begin
                  r_state <= FETCH;
                  r_col   <= '0;
                  r_addr  <= coef_ad('0, '0);
                  r_busy  <= 1'b1;
               end
            end
            FETCH: begin
               r_state <= MAC;
               r_k     <= '0;
               r_addr  <= coef_ad(r_col, K_W'(1));
               r_shift <= 1'b1;
            end
            MAC: begin
               if (r_k == K_W'(K_LEN-1)) begin
                  r_state <= HOLD;
                  r_shift <= 1'b0;
                  r_valid <= 1'b1;
               end else begin
                  r_k    <= r_k + 1'b1;
                  r_addr <= coef_ad(r_col, (r_k >= K_W'(K_LEN-3)) ? K_W'(K_LEN-1)
                                                                  : r_k + K_W'(2));
               end
            end
            HOLD: begin
               if (bus.res_ready) begin
                  r_valid <= 1'b0;
                  if (r_col == COL_W'(N_COL-1)) begin
                     r_state <= IDLE;
                     r_col   <= '0;
                     r_addr  <= '0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= FETCH;
                     r_col   <= r_col + 1'b1;
                     r_addr  <= coef_ad(r_col + 1'b1, '0);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac_array.sv
// Scoreboard bench for mac_array with a model X buffer and synchronous ROM.
module tb_mac_array;
   import mac_pkg::*;

   typedef struct packed {
      logic [COL_W-1:0]               col;
      logic [NUM_LANES-1:0][ACC_W-1:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic reload;
   logic [2:0] ptr = 3'd0;
   logic [DATA_W-1:0] xbuf [4][8];
   logic [DATA_W-1:0] rom  [32];
   exp_t q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int n_shift  = 0;
   int n_done   = 0;
   int n_hs     = 0;

   mac_array_if bus();
   mac_array dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      bus.coef_data <= rom[bus.coef_addr];
      if (reload)           ptr <= 3'd0;
      else if (bus.x_shift) ptr <= ptr + 3'd1;
   end
   assign bus.x_in1 = xbuf[0][ptr];
   assign bus.x_in2 = xbuf[1][ptr];
   assign bus.x_in3 = xbuf[2][ptr];
   assign bus.x_in4 = xbuf[3][ptr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Hand-derived closed forms for each stimulus pattern
   function automatic logic [ACC_W-1:0] expv(input int mode, input int i, input int j);
      case (mode)
         0:       return ACC_W'(8);
         1:       return ACC_W'(8 * (i+1) * (j+1));
         2:       return ACC_W'(520200);
         default: return ACC_W'((i+1) * (140 + 28*j));
      endcase
   endfunction

   task automatic load(input int mode);
      for (int i = 0; i < 4; i++)
         for (int k = 0; k < 8; k++)
            case (mode)
               0: xbuf[i][k] = 8'd1;
               1: xbuf[i][k] = 8'(i+1);
               2: xbuf[i][k] = 8'd255;
               default: xbuf[i][k] = 8'((i+1)*k);
            endcase
      for (int j = 0; j < 4; j++)
         for (int k = 0; k < 8; k++)
            case (mode)
               0: rom[j*8+k] = 8'd1;
               1: rom[j*8+k] = 8'(j+1);
               2: rom[j*8+k] = 8'd255;
               default: rom[j*8+k] = 8'(k+j);
            endcase
      @(negedge clk) reload = 1'b1;
      @(negedge clk) reload = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.x_shift) n_shift++;
         if (bus.done)    n_done++;
         if (bus.res_valid && bus.res_ready) begin
            n_hs++;
            if (q.size() == 0) check("unexpected_result", 32'(bus.res_col), 32'hFFFF);
            else begin
               exp_t e;
               e = q.pop_front();
               check("res_col", 32'(bus.res_col), 32'(e.col));
               check("res_data1", 32'(bus.res_data1), 32'(e.d[0]));
               check("res_data2", 32'(bus.res_data2), 32'(e.d[1]));
               check("res_data3", 32'(bus.res_data3), 32'(e.d[2]));
               check("res_data4", 32'(bus.res_data4), 32'(e.d[3]));
            end
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"},      32'(bus.busy), 0);
      check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
      check({tag, "_x_shift"},   32'(bus.x_shift), 0);
      check({tag, "_coef_addr"}, 32'(bus.coef_addr), 0);
      check({tag, "_done"},      32'(bus.done), 0);
      check({tag, "_res_col"},   32'(bus.res_col), 0);
      check({tag, "_res_data1"}, 32'(bus.res_data1), 0);
   endtask

   task automatic run_product(input int mode, input bit stall, input bit glitch, input bit abort);
      int n, s_shift, s_done, s_hs, exp_n;
      bit fin;
      exp_t e;
      for (int j = 0; j < 4; j++) begin
         e.col = COL_W'(j);
         for (int i = 0; i < 4; i++) e.d[i] = expv(mode, i, j);
         q.push_back(e);
      end
      s_shift = n_shift; s_done = n_done; s_hs = n_hs;
      exp_n = stall ? 45 : 40;
      @(negedge clk) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = 0; fin = 1'b0;
      while (!fin && n < 200) begin
         @(negedge clk);
         if (stall && n >= 19 && n <= 23) begin
            check("stall_valid", 32'(bus.res_valid), 1);
            check("stall_x_shift", 32'(bus.x_shift), 0);
            check("stall_coef_addr", 32'(bus.coef_addr), 15);
            check("stall_res_col", 32'(bus.res_col), 1);
            check("stall_res_data1", 32'(bus.res_data1), 32'(expv(mode, 0, 1)));
         end
         if (abort && n == 24) begin
            rst = 1'b1;
            @(negedge clk);
            check_idle_outputs("abort");
            q.delete();
            #1 rst = 1'b0;
            return;
         end
         if (bus.done) begin
            fin = 1'b1;
            check("busy_at_done", 32'(bus.busy), 0);
         end else begin
            @(posedge clk);
            n++;
            #1;
            if (glitch) bus.start = (n == 3);
            if (stall)  bus.res_ready = !(n >= 19 && n <= 23);
         end
      end
      check("done_seen", 32'(fin), 1);
      check("done_cycle", 32'(n), 32'(exp_n));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("done_one_cycle", 32'(bus.done), 0);
      check("x_shift_count", 32'(n_shift - s_shift), 32);
      check("done_count", 32'(n_done - s_done), 1);
      check("handshakes", 32'(n_hs - s_hs), 4);
      check("queue_empty", 32'(q.size()), 0);
   endtask

   initial begin
      rst = 1'b1; reload = 1'b0;
      bus.start = 1'b0; bus.res_ready = 1'b1;
      for (int a = 0; a < 32; a++) rom[a] = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk) #1 rst = 1'b0;

      load(0); run_product(0, 1'b0, 1'b0, 1'b0);
      load(1); run_product(1, 1'b0, 1'b0, 1'b0);
      load(2); run_product(2, 1'b0, 1'b1, 1'b0);
      load(3); run_product(3, 1'b1, 1'b0, 1'b0);
      load(1); run_product(1, 1'b0, 1'b0, 1'b1);
      load(3); run_product(3, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
